// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV instruction decoder with 2-entry skid buffer
//
// Decodes one instruction per cycle into control bits, register fields and a
// sign-extended XLEN immediate. Results sit in a main/skid register pair so
// in_ready depends only on a flop, never on out_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop both buffered bundles and the same-cycle input
//   in_valid/in_ready        fetch handshake; in_instr, in_pc carry the payload
//   out_valid/out_ready      execute handshake
//   out_pc, out_rs1/rs2/rd, out_func3, out_func7, out_imm   decoded fields
//   out_write_reg .. out_word_op, out_alu_op, out_illegal   control bits

module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_write_reg,
  output logic            out_mem2reg,
  output logic            out_read_mem,
  output logic            out_write_mem,
  output logic            out_alu_src,
  output logic            out_pc_src,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_word_op,
  output logic [1:0]      out_alu_op,
  output logic            out_illegal
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic            write_reg;
    logic            mem2reg;
    logic            read_mem;
    logic            write_mem;
    logic            alu_src;
    logic            pc_src;
    logic            branch;
    logic            jump;
    logic            word_op;
    logic [1:0]      alu_op;
    logic            illegal;
  } bundle_t;

  bundle_t         dec;
  bundle_t         main_q;
  bundle_t         skid_q;
  logic            main_valid;
  logic            skid_valid;
  logic            consume;
  logic            accept;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  // Size casts of signed operands replicate instr[31] up to XLEN.
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.rs1   = in_instr[19:15];
    dec.rs2   = in_instr[24:20];
    dec.rd    = in_instr[11:7];
    dec.func3 = in_instr[14:12];
    dec.func7 = in_instr[31:25];
    // Every legal opcode ends in 2'b11, so a bad low pair falls into default.
    case (in_instr[6:0])
      7'b0000011: begin
        dec.write_reg = 1'b1; dec.mem2reg = 1'b1; dec.read_mem = 1'b1;
        dec.alu_src = 1'b1; dec.imm = imm_i;
      end
      7'b0100011: begin
        dec.write_mem = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_s;
      end
      7'b0010011: begin
        dec.write_reg = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b11; dec.imm = imm_i;
      end
      7'b0110011: begin
        dec.write_reg = 1'b1; dec.alu_op = 2'b10;
      end
      7'b1100011: begin
        dec.pc_src = 1'b1; dec.branch = 1'b1; dec.alu_op = 2'b01; dec.imm = imm_b;
      end
      7'b1101111: begin
        dec.write_reg = 1'b1; dec.alu_src = 1'b1; dec.pc_src = 1'b1;
        dec.jump = 1'b1; dec.imm = imm_j;
      end
      7'b1100111: begin
        dec.write_reg = 1'b1; dec.alu_src = 1'b1; dec.jump = 1'b1; dec.imm = imm_i;
      end
      7'b0110111: begin
        dec.write_reg = 1'b1; dec.alu_src = 1'b1; dec.imm = imm_u;
      end
      7'b0010111: begin
        dec.write_reg = 1'b1; dec.alu_src = 1'b1; dec.pc_src = 1'b1; dec.imm = imm_u;
      end
      7'b0001111: ;
      7'b0011011: begin
        if (XLEN == 64) begin
          dec.write_reg = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b11;
          dec.word_op = 1'b1; dec.imm = imm_i;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'b0111011: begin
        if (XLEN == 64) begin
          dec.write_reg = 1'b1; dec.alu_op = 2'b10; dec.word_op = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    if (in_instr[11:7] == 5'd0) dec.write_reg = 1'b0;
  end

  assign consume = main_valid & out_ready;
  assign accept  = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume && skid_valid) begin
      // in_ready is low whenever skid is full, so no accept can collide here.
      main_q     <= skid_q;
      skid_valid <= 1'b0;
    end else if (accept && (!main_valid || consume)) begin
      main_q     <= dec;
      main_valid <= 1'b1;
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end else if (consume) begin
      main_valid <= 1'b0;
    end
  end

  assign in_ready      = ~skid_valid;
  assign out_valid     = main_valid;
  assign out_pc        = main_q.pc;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_func3     = main_q.func3;
  assign out_func7     = main_q.func7;
  assign out_imm       = main_q.imm;
  assign out_write_reg = main_q.write_reg;
  assign out_mem2reg   = main_q.mem2reg;
  assign out_read_mem  = main_q.read_mem;
  assign out_write_mem = main_q.write_mem;
  assign out_alu_src   = main_q.alu_src;
  assign out_pc_src    = main_q.pc_src;
  assign out_branch    = main_q.branch;
  assign out_jump      = main_q.jump;
  assign out_word_op   = main_q.word_op;
  assign out_alu_op    = main_q.alu_op;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - bench for decode_stage at XLEN=32 and XLEN=64
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [11:0] ctl;  // wr m2r rm wm as ps br jp alu[1:0] wo ill
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        i_ready [2];
  logic        o_valid [2];
  logic [31:0] o_pc [2];
  logic [4:0]  o_rs1 [2];
  logic [4:0]  o_rs2 [2];
  logic [4:0]  o_rd [2];
  logic [2:0]  o_f3 [2];
  logic [6:0]  o_f7 [2];
  logic [31:0] o_imm32;
  logic [63:0] o_imm64;
  logic        o_wr [2], o_m2r [2], o_rm [2], o_wm [2], o_as [2];
  logic        o_ps [2], o_br [2], o_jp [2], o_wo [2], o_ill [2];
  logic [1:0]  o_alu [2];

  int checks = 0;
  int failures = 0;
  bit started = 0;
  logic [63:0] q [$];  // {pc, instr} of bundles the stage should be holding, oldest first

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(i_ready[0]),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_pc(o_pc[0]), .out_rs1(o_rs1[0]), .out_rs2(o_rs2[0]), .out_rd(o_rd[0]),
    .out_func3(o_f3[0]), .out_func7(o_f7[0]), .out_imm(o_imm32),
    .out_write_reg(o_wr[0]), .out_mem2reg(o_m2r[0]), .out_read_mem(o_rm[0]),
    .out_write_mem(o_wm[0]), .out_alu_src(o_as[0]), .out_pc_src(o_ps[0]),
    .out_branch(o_br[0]), .out_jump(o_jp[0]), .out_word_op(o_wo[0]),
    .out_alu_op(o_alu[0]), .out_illegal(o_ill[0]));

  decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(i_ready[1]),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_pc(o_pc[1]), .out_rs1(o_rs1[1]), .out_rs2(o_rs2[1]), .out_rd(o_rd[1]),
    .out_func3(o_f3[1]), .out_func7(o_f7[1]), .out_imm(o_imm64),
    .out_write_reg(o_wr[1]), .out_mem2reg(o_m2r[1]), .out_read_mem(o_rm[1]),
    .out_write_mem(o_wm[1]), .out_alu_src(o_as[1]), .out_pc_src(o_ps[1]),
    .out_branch(o_br[1]), .out_jump(o_jp[1]), .out_word_op(o_wo[1]),
    .out_alu_op(o_alu[1]), .out_illegal(o_ill[1]));

  // Reference decoder: opcode table plus integer arithmetic for the immediates.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc, input bit is64);
    exp_t e;
    logic [9:0] base;
    byte fmt;
    bit legal, wo;
    longint v;
    e = '0;
    e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.f3 = ins[14:12]; e.f7 = ins[31:25];
    legal = 1; wo = 0; base = 10'b0; fmt = "N";
    case (ins[6:0])
      7'b0000011: begin base = 10'b1110100000; fmt = "I"; end
      7'b0100011: begin base = 10'b0001100000; fmt = "S"; end
      7'b0010011: begin base = 10'b1000100011; fmt = "I"; end
      7'b0110011: begin base = 10'b1000000010; end
      7'b1100011: begin base = 10'b0000011001; fmt = "B"; end
      7'b1101111: begin base = 10'b1000110100; fmt = "J"; end
      7'b1100111: begin base = 10'b1000100100; fmt = "I"; end
      7'b0110111: begin base = 10'b1000100000; fmt = "U"; end
      7'b0010111: begin base = 10'b1000110000; fmt = "U"; end
      7'b0001111: ;
      7'b0011011: begin legal = is64; wo = 1; base = 10'b1000100011; fmt = "I"; end
      7'b0111011: begin legal = is64; wo = 1; base = 10'b1000000010; end
      default: legal = 0;
    endcase
    v = 0;
    case (fmt)
      "I": begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; end
      "S": begin v = longint'({ins[31:25], ins[11:7]}); if (v >= 2048) v -= 4096; end
      "B": begin
        v = longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
        if (v >= 4096) v -= 8192;
      end
      "U": begin v = longint'(ins[31:12]) * 4096; if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000; end
      "J": begin
        v = longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    if (!legal) begin
      e.ctl = 12'b1;
      e.imm = '0;
    end else begin
      e.ctl = {base, wo, 1'b0};
      e.imm = v;
      if (ins[11:7] == 5'd0) e.ctl[11] = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t act(input int k);
    exp_t a;
    a.pc = o_pc[k]; a.rs1 = o_rs1[k]; a.rs2 = o_rs2[k]; a.rd = o_rd[k];
    a.f3 = o_f3[k]; a.f7 = o_f7[k];
    a.imm = (k == 1) ? o_imm64 : 64'(longint'($signed(o_imm32)));
    a.ctl = {o_wr[k], o_m2r[k], o_rm[k], o_wm[k], o_as[k], o_ps[k], o_br[k], o_jp[k],
             o_alu[k], o_wo[k], o_ill[k]};
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Occupancy model: the stage holds up to two bundles in arrival order.
  always @(posedge clk) begin
    bit pop, push;
    if (rst || flush) begin
      q.delete();
    end else begin
      pop  = (q.size() > 0) && out_ready;
      push = in_valid && (q.size() < 2);
      if (pop) void'(q.pop_front());
      if (push) q.push_back({in_pc, in_instr});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (i_ready[k] !== (q.size() < 2) || o_valid[k] !== (q.size() > 0)) begin
          failures++;
          $display("FAIL handshake%0d got ready=%b valid=%b want ready=%b valid=%b",
                   k, i_ready[k], o_valid[k], q.size() < 2, q.size() > 0);
        end
        if (q.size() > 0) begin
          exp_t e, a;
          e = ref_dec(q[0][31:0], q[0][63:32], k == 1);
          a = act(k);
          checks++;
          if (a !== e) begin
            failures++;
            $display("FAIL bundle%0d got=%h want=%h", k, a, e);
          end
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                     input bit ordy, input bit fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] OPS [12] = '{32'h03, 32'h23, 32'h13, 32'h33, 32'h63, 32'h6f,
                                       32'h67, 32'h37, 32'h17, 32'h0f, 32'h1b, 32'h3b};

  initial begin
    exp_t z;
    logic [31:0] r, ins;
    rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
    cyc(0, 0, 0, 0, 0);
    started = 1;
    cyc(1, 32'h00500093, 32'h40, 1, 0);
    z = '0;
    for (int k = 0; k < 2; k++) begin
      check("reset_valid", 64'(o_valid[k]), 0);
      check("reset_ready", 64'(i_ready[k]), 1);
      check("reset_fields", 64'(act(k) != z), 0);
    end
    rst = 0;

    cyc(1, 32'h00500093, 32'h100, 1, 0);
    check("addi_valid", 64'(o_valid[0]), 1);
    check("addi_imm", 64'(o_imm32), 5);
    check("addi_alu", 64'(o_alu[0]), 2'b11);
    check("addi_wr_as_ill", {o_wr[0], o_as[0], o_ill[0]}, 3'b110);
    cyc(1, 32'hFE000EE3, 32'h104, 1, 0);
    check("beq_imm32", 64'(o_imm32), 32'hFFFF_FFFC);
    check("beq_imm64", o_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq_br_ps_wr", {o_br[1], o_ps[1], o_wr[1]}, 3'b110);
    cyc(1, 32'h0080006F, 32'h108, 1, 0);
    check("jal_imm", o_imm64, 8);
    check("jal_jump", 64'(o_jp[0]), 1);
    cyc(1, 32'h0000003B, 32'h10C, 1, 0);
    check("op32_ill_x32", 64'(act(0).ctl), 12'b1);
    check("op32_x64", 64'(act(1).ctl), 12'b0000_0000_1010);
    cyc(1, 32'h00000000, 32'h110, 1, 0);
    check("zero_ill", {o_ill[0], o_ill[1]}, 2'b11);
    cyc(1, 32'h00100013, 32'h114, 1, 0);
    check("addi_x0_wr", {o_wr[0], o_wr[1], o_as[0]}, 3'b001);
    cyc(0, 0, 0, 1, 0);

    // Back-pressure: two entries buffered, third held off, released in order.
    cyc(1, 32'h00108113, 32'h200, 0, 0);
    cyc(1, 32'h00210193, 32'h204, 0, 0);
    check("full_ready", 64'(i_ready[0]), 0);
    cyc(1, 32'h00318213, 32'h208, 0, 0);
    check("hold_pc", 64'(o_pc[0]), 32'h200);
    cyc(1, 32'h00318213, 32'h208, 1, 0);
    check("release_pc", 64'(o_pc[0]), 32'h204);
    check("release_ready", 64'(i_ready[1]), 1);
    cyc(1, 32'h00318213, 32'h208, 1, 0);
    check("nobubble_pc", 64'(o_pc[1]), 32'h208);
    cyc(0, 0, 0, 1, 0);
    check("drained", 64'(o_valid[0]), 0);

    // Flush with both slots full and a new offer.
    cyc(1, 32'h00108113, 32'h300, 0, 0);
    cyc(1, 32'h00210193, 32'h304, 0, 0);
    cyc(1, 32'h00318213, 32'h308, 0, 1);
    check("flush_valid", {o_valid[0], o_valid[1]}, 2'b00);
    check("flush_ready", {i_ready[0], i_ready[1]}, 2'b11);
    cyc(0, 0, 0, 1, 0);

    // Random mix; the per-cycle compare does the checking.
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      ins = $urandom();
      if (r[3:0] != 4'd0) ins = {ins[31:7], OPS[r[7:4] % 12][6:0]};
      rst = (r[15:10] == 6'd0);
      cyc(r[17:16] != 2'b00, ins, $urandom(), r[19:18] != 2'b00, r[24:20] == 5'd0);
    end
    rst = 0;
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
